mp_add_sequencer: RTL and testbench
===================================

Name: mp_add_sequencer

Overview:
Multi-precision add/subtract controller. It sequences one 16-bit adder slice over WORDS clock cycles, least-significant word first, chaining the carry between words to produce a W*WORDS-bit sum or difference. It sits between a requester (valid/ready operand interface) and a consumer (valid/ready result interface), so wide arithmetic is done on a single narrow adder.

Parameters:
W, 16, adder slice width in bits
WORDS, 4, number of slices per operand (legal range 2..16); operand width = W*WORDS

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept a request
op_a  in  W*WORDS  operand A
op_b  in  W*WORDS  operand B
op_sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored)
cin  in  1  carry-in for add
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  W*WORDS  sum/difference
cout  out  1  carry-out of top slice (for subtract: 1 = no borrow)
ovf  out  1  signed two's-complement overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Reset: state=IDLE, in_ready=0 during reset then 1, out_valid=0, result=0, cout=0, ovf=0, busy=0, idx=0, carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch op_a, op_b (op_b stored bitwise-inverted when op_sub=1); carry <= op_sub ? 1 : cin; idx <= 0; go to RUN.
- RUN (exactly WORDS cycles): in_ready=0. Each cycle: {c,s} = A[idx] + B'[idx] + carry. result[idx] <= s; carry <= c; idx <= idx+1.
- RUN, last word (idx==WORDS-1): also cout <= c; ovf <= carry-in to the MSB XOR c, computed as A_msb ^ B'_msb ^ s_msb ^ c. Go to DONE.
- DONE: out_valid=1; result, cout and ovf are stable. On out_ready go to IDLE (out_valid=0 next cycle).
- Latency: acceptance edge at cycle N gives out_valid high from cycle N+WORDS+1 (first cycle in DONE). Throughput: one operation per WORDS+2 cycles minimum.
- No same-cycle accept in DONE: in_ready stays 0 until back in IDLE. An in_valid held during RUN/DONE is accepted in the first IDLE cycle.
- result is written word by word during RUN. It is only meaningful while out_valid=1.
- Backpressure: out_ready low holds DONE indefinitely, with all outputs unchanged.
- Mid-operation reset: rst in any state returns to IDLE the next edge and discards the in-flight operation. No out_valid is produced for it.
- idx width: clog2(WORDS); it wraps to 0 only via a new accept.
- Wrap-around arithmetic: result is modulo 2^(W*WORDS). The carry out of the top word goes only to cout.

Decomposition:
- Package mp_add_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default W and WORDS constants.
- One sub-module, add_slice: purely combinational W-bit adder with inputs a, b, ci and outputs s, co. It is instantiated once; the sequencer owns all registers.

Test Plan:
- Add, WORDS=4: A=0x0000_0000_0000_158A, B=0x0000_0000_0000_7095, cin=0 -> result=0x0000_0000_0000_861F, cout=0, ovf=0, out_valid exactly 5 cycles after the accept edge.
- Carry ripple: A=0x0000_0000_0000_FFFF, B=1, cin=0 -> 0x0000_0000_0001_0000. Then A=all-ones, B=0, cin=1 -> result=0, cout=1, ovf=0.
- Subtract: A=5, B=7, op_sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0. Then A=0x8000_0000_0000_0000, B=1, op_sub=1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Signed overflow on add: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> 0x8000_0000_0000_0000, ovf=1, cout=0.
- Backpressure/handshake: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> result stable, in_ready=0 throughout. After out_ready=1, in_ready=1 the next cycle and the second request is accepted then.
- Reset mid-RUN: assert rst for 1 cycle at idx=2 -> next cycle state=IDLE, out_valid=0, busy=0, in_ready=1. A following add of 0x158A+0x7095 completes correctly.

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   state_e      : sequencer FSM state encoding
//   DefaultW     : default adder slice width in bits
//   DefaultWords : default number of slices per operand
package mp_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultW     = 16;
  localparam int unsigned DefaultWords = 4;

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit adder slice with carry in and carry out.
// Ports:
//   a, b : W-bit addends
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out of the slice
module add_slice #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s   = sum[W-1:0];
  assign co  = sum[W];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer. Runs one W-bit adder slice over WORDS cycles,
// least-significant word first, chaining the carry to form a W*WORDS-bit result.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   in_valid/in_ready : operand handshake (op_a, op_b, op_sub, cin)
//   out_valid/out_ready : result handshake (result, cout, ovf)
//   busy              : high while an operation is running or waiting to be consumed
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned WORDS = DefaultWords
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*WORDS-1:0] op_a,
  input  logic [W*WORDS-1:0] op_b,
  input  logic               op_sub,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*WORDS-1:0] result,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);

  localparam int unsigned IdxW = $clog2(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e                     state_q, state_d;
  logic [WORDS-1:0][W-1:0]    a_q, a_d;
  logic [WORDS-1:0][W-1:0]    b_q, b_d;      // holds ~op_b for subtract
  logic [WORDS-1:0][W-1:0]    result_q, result_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic                       carry_q, carry_d;
  logic                       cout_q, cout_d;
  logic                       ovf_q, ovf_d;

  logic [W-1:0]               slice_s;
  logic                       slice_co;

  add_slice #(
    .W (W)
  ) u_add_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          // Subtract is A + ~B + 1, so the external carry-in is ignored.
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[idx_q] = slice_s;
        carry_d         = slice_co;
        if (idx_q == LastIdx) begin
          cout_d  = slice_co;
          // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry out.
          ovf_d   = a_q[idx_q][W-1] ^ b_q[idx_q][W-1] ^ slice_s[W-1] ^ slice_co;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // in_ready is masked by rst so no request is taken while reset is held.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
module tb_mp_add_sequencer;

  localparam int unsigned W     = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N     = W * WORDS;
  localparam int          Lat   = WORDS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int tests = 0;
  int fails = 0;

  mp_add_sequencer #(
    .W     (W),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         ci;
    logic [N-1:0] exp_res;
    logic         exp_co;
    logic         exp_ov;
  } vec_t;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: whole-width arithmetic on the operand values, signed overflow from sign rules.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input logic ci, output logic [N-1:0] r, output logic co,
                       output logic ov);
    logic [N:0]   t;
    logic [N-1:0] bp;
    bp = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bp} + {{N{1'b0}}, (sub ? 1'b1 : ci)};
    r  = t[N-1:0];
    co = t[N];
    ov = (a[N-1] == bp[N-1]) && (r[N-1] != a[N-1]);
  endtask

  // Issues one request, waits for the result and consumes it after hold cycles of backpressure.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                        input logic ci, input int hold, output logic [N-1:0] r,
                        output logic co, output logic ov, output int lat);
    int guard;
    logic [N-1:0] r0;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; cin = ci; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = result; co = cout; ov = ovf;
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", result, r0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {63'd0, out_valid}, 64'd0);
  endtask

  vec_t         vecs[$];
  logic [N-1:0] r, er;
  logic         co, ov, eco, eov;
  int           lat;
  int           seen;

  initial begin
    vecs.push_back('{64'h158A, 64'h7095, 1'b0, 1'b0, 64'h861F, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0});
    vecs.push_back('{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1});

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; cin = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci, 0, r, co, ov, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
      check($sformatf("vec%0d_cout", i), {63'd0, co}, {63'd0, vecs[i].exp_co});
      check($sformatf("vec%0d_ovf", i), {63'd0, ov}, {63'd0, vecs[i].exp_ov});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(Lat));
    end

    // Backpressure with a second request waiting
    @(negedge clk);
    op_a = 64'h158A; op_b = 64'h7095; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 64'h7FFF_FFFF_FFFF_FFFF; op_b = 64'h1;
    seen = 0;
    while (!out_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_result", result, 64'h861F);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_valid", {63'd0, out_valid}, 64'd0);
    check("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_busy", {63'd0, busy}, 64'd1);
    seen = 0;
    while (!out_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check("bp_second_result", result, 64'h8000_0000_0000_0000);
    check("bp_second_ovf", {63'd0, ovf}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of RUN (idx == 2)
    op_a = 64'hFFFF_FFFF; op_b = 64'h1; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < WORDS + 3; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    run_op(64'h158A, 64'h7095, 1'b0, 1'b0, 0, r, co, ov, lat);
    check("post_rst_result", r, 64'h861F);
    check("post_rst_latency", 64'(lat), 64'(Lat));

    // Randomized operations against the reference
    for (int i = 0; i < 150; i++) begin
      logic [N-1:0] a, b;
      logic sub, ci;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0: a = '1;
        1: b = '0;
        2: a = {1'b0, {(N-1){1'b1}}};
        3: b = {1'b1, {(N-1){1'b0}}};
        default: ;
      endcase
      sub = 1'($urandom_range(0, 1));
      ci  = 1'($urandom_range(0, 1));
      model(a, b, sub, ci, er, eco, eov);
      run_op(a, b, sub, ci, $urandom_range(0, 2), r, co, ov, lat);
      check($sformatf("rnd%0d_result", i), r, er);
      check($sformatf("rnd%0d_cout", i), {63'd0, co}, {63'd0, eco});
      check($sformatf("rnd%0d_ovf", i), {63'd0, ov}, {63'd0, eov});
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(Lat));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
